// File: rtl/redmule_tcdm_splitter.sv
// rtl/redmule_tcdm_splitter.sv - splits one wide TCDM master port into MP narrow TCDM ports
// Tracks per-port grants and read responses so the wide side sees one grant and one aligned response.
module redmule_tcdm_splitter #(
    parameter int DW = 128,
    parameter int MP = 4,
    parameter int AW = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 in_req_i,
    output logic                 in_gnt_o,
    input  logic [AW-1:0]        in_add_i,
    input  logic                 in_wen_i,
    input  logic [DW/8-1:0]      in_be_i,
    input  logic [DW-1:0]        in_data_i,
    output logic [DW-1:0]        in_r_data_o,
    output logic                 in_r_valid_o,
    output logic [MP-1:0]        out_req_o,
    input  logic [MP-1:0]        out_gnt_i,
    output logic [MP*AW-1:0]     out_add_o,
    output logic [MP-1:0]        out_wen_o,
    output logic [DW/8-1:0]      out_be_o,
    output logic [DW-1:0]        out_data_o,
    input  logic [DW-1:0]        out_r_data_i,
    input  logic [MP-1:0]        out_r_valid_i,
    output logic                 err_o
);

    localparam int NW = DW / MP;
    localparam int NB = NW / 8;

    logic [MP-1:0]         g_q;
    logic [MP-1:0]         v_q;
    logic                  rd_pend_q;
    logic                  err_q;
    logic [MP-1:0][NW-1:0] rbuf_q;

    logic                  issue_ok;
    logic                  rd_done;
    logic                  all_g;
    logic [MP-1:0]         req;
    logic [MP-1:0]         fire;

    // issue_ok depends only on response-side signals, so grants never feed back into requests
    always_comb begin
        rd_done  = rd_pend_q & (&(v_q | out_r_valid_i));
        issue_ok = ~rd_pend_q | rd_done;
        req      = {MP{in_req_i & issue_ok & ~rst_i}} & ~g_q;
        fire     = req & out_gnt_i;
        all_g    = &(g_q | fire);
    end

    assign out_req_o    = req;
    assign in_gnt_o     = in_req_i & issue_ok & all_g & ~rst_i;
    assign in_r_valid_o = rd_done;
    assign err_o        = err_q;
    assign out_wen_o    = {MP{in_wen_i}};
    assign out_be_o     = in_be_i;
    assign out_data_o   = in_data_i;

    for (genvar ii = 0; ii < MP; ii++) begin : g_slice
        assign out_add_o[ii*AW +: AW]  = in_add_i + AW'(ii * NB);
        assign in_r_data_o[ii*NW +: NW] = v_q[ii] ? rbuf_q[ii] : out_r_data_i[ii*NW +: NW];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            g_q       <= '0;
            v_q       <= '0;
            rd_pend_q <= 1'b0;
            err_q     <= 1'b0;
            rbuf_q    <= '0;
        end else begin
            g_q <= in_gnt_o ? '0 : (g_q | fire);

            if (in_gnt_o && in_wen_i) begin
                rd_pend_q <= 1'b1;
            end else if (rd_done) begin
                rd_pend_q <= 1'b0;
            end

            if (rd_done) begin
                v_q <= '0;
            end else if (rd_pend_q) begin
                v_q <= v_q | out_r_valid_i;
            end

            for (int ii = 0; ii < MP; ii++) begin
                if (rd_pend_q && out_r_valid_i[ii] && !v_q[ii]) begin
                    rbuf_q[ii] <= out_r_data_i[ii*NW +: NW];
                end
            end

            // spurious or duplicate narrow responses are dropped and only flagged here
            if (|(out_r_valid_i & (v_q | {MP{~rd_pend_q}}))) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule
